hazard_ctrl: RTL and testbench

//  Pipeline hazard/stall controller for the 5-stage CPU. Generates the write enables and

---
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes, multiply and memory holds.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       ex_mul_start,
  input  logic       mem_busy,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_en,
  output logic       id_ex_bubble
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int unsigned MC_W = $clog2(MUL_LAT);
  localparam logic [MC_W-1:0] MUL_CNT_INIT = MC_W'(MUL_LAT - 2);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MC_W-1:0] r_mul_cnt;
  logic [MC_W-1:0] w_mul_cnt_nxt;
  logic            w_load_use;
  logic            w_rs_hit;
  logic            w_rt_hit;

  assign w_rs_hit   = id_uses_rs & (id_rs == ex_rd);
  assign w_rt_hit   = id_uses_rt & (id_rt == ex_rd);
  assign w_load_use = ex_memread & (ex_rd != 5'd0) & (w_rs_hit | w_rt_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_mul_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
    end
  end

  // Multiply hold keeps counting down even while memory is busy.
  always_comb begin
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    case (r_state)
      ST_RUN: begin
        if (ex_mul_start) begin
          w_state_nxt   = ST_MUL_WAIT;
          w_mul_cnt_nxt = MUL_CNT_INIT;
        end
      end
      ST_MUL_WAIT: begin
        if (r_mul_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_mul_cnt_nxt = r_mul_cnt - MC_W'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_RUN;
        w_mul_cnt_nxt = '0;
      end
    endcase
  end

  // Priority: reset, mem_busy, multiply hold, taken branch, load-use, free run.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_bubble = 1'b0;
    if (!rst_n) begin
      pc_en = 1'b1;
    end else if (mem_busy || (r_state == ST_MUL_WAIT)) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (if_id_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs, a monitor checks them.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam logic [4:0] NRM = 5'b11010;
  localparam logic [4:0] HLD = 5'b00000;
  localparam logic [4:0] BRF = 5'b11111;
  localparam logic [4:0] LUS = 5'b00011;
  localparam int         TB_CNT_W = 4;
  localparam int         CNT_MAX  = (1 << TB_CNT_W) - 1;

  typedef struct {
    logic       rst_n;
    logic [4:0] exp;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_memread;
  logic       ex_branch_taken, ex_mul_start, mem_busy;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
  logic [4:0] outs;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

`ifdef HAZ_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;
  int m_stall = 0;
  int m_flush = 0;
`endif

  always #5 clk = ~clk;

  assign outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble};

`ifdef HAZ_PERF_CNT_EN
  hazard_ctrl #(.MUL_LAT(4), .CNT_W(TB_CNT_W)) dut (
`else
  hazard_ctrl #(.MUL_LAT(4)) dut (
`endif
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_mul_start(ex_mul_start), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // Monitor: one expected entry per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (outs === e.exp) n_pass++;
        else $display("FAIL %s: outs(pc,ifid,flush,idex,bubble)=%b expected=%b", e.name, outs, e.exp);
`ifdef HAZ_PERF_CNT_EN
        if (!e.rst_n) begin
          m_stall = 0;
          m_flush = 0;
        end
        n_chk++;
        if (int'(stall_cnt) == m_stall) n_pass++;
        else $display("FAIL %s_stall_cnt: got=%0d expected=%0d", e.name, stall_cnt, m_stall);
        n_chk++;
        if (int'(flush_cnt) == m_flush) n_pass++;
        else $display("FAIL %s_flush_cnt: got=%0d expected=%0d", e.name, flush_cnt, m_flush);
        if (e.rst_n) begin
          if (!e.exp[4] && m_stall < CNT_MAX) m_stall++;
          if (e.exp[2] && m_flush < CNT_MAX) m_flush++;
        end
`endif
      end
    end
  end

  task automatic step(input logic rst, input logic busy, input logic mread,
                      input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic br, input logic mul,
                      input logic [4:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; mem_busy = busy; ex_memread = mread; ex_rd = rd;
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_branch_taken = br; ex_mul_start = mul;
    e.rst_n = rst; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] exp, input string name);
    step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, exp, name);
  endtask

  task automatic mul_start(input string name);
    step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, NRM, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mem_busy = 0; ex_memread = 0; ex_rd = 0; id_rs = 0; id_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_branch_taken = 0; ex_mul_start = 0;

    // Reset: inputs ignored, free-run outputs
    step(0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, NRM, "reset_outputs");
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, "reset_hold");
    idle(NRM, "first_after_reset");

    // Load-use
    step(1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, LUS, "lu_rs");
    step(1, 0, 0, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, NRM, "lu_rs_after");
    step(1, 0, 1, 5'd7, 5'd3, 5'd7, 1, 1, 0, 0, LUS, "lu_rt");
    idle(NRM, "lu_rt_after");
    step(1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, NRM, "rd_zero");
    step(1, 0, 1, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, NRM, "no_use");
    step(1, 0, 1, 5'd5, 5'd4, 5'd6, 1, 1, 0, 0, NRM, "no_match");
    step(1, 0, 0, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, NRM, "not_load");

    // Branch wins over load-use, no stall after
    step(1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, BRF, "br_over_lu");
    idle(NRM, "br_after");
    step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, BRF, "br_plain");

    // Multiply hold, start pulse ignored while holding
    mul_start("mul_start");
    step(1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, HLD, "mul_hold1");
    idle(HLD, "mul_hold2");
    step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, HLD, "mul_hold3");
    idle(NRM, "mul_done");

    // Multiply hold overlapping mem_busy keeps the same length
    mul_start("mulb_start");
    step(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, HLD, "mulb_hold1");
    step(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, HLD, "mulb_hold2");
    idle(HLD, "mulb_hold3");
    idle(NRM, "mulb_done");

    // mem_busy freezes a taken branch and a load-use
    step(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, HLD, "busy_br");
    step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, BRF, "br_after_busy");
    step(1, 1, 1, 5'd9, 5'd9, 5'd0, 1, 0, 0, 0, HLD, "busy_lu");
    step(1, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0, 0, 0, LUS, "lu_after_busy");

    // Reset in the middle of a multiply hold
    mul_start("mulr_start");
    idle(HLD, "mulr_hold1");
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, NRM, "rst_mid_mul");
    idle(NRM, "after_rst");
    mul_start("mul2_start");
    idle(HLD, "mul2_hold1");
    idle(HLD, "mul2_hold2");
    idle(HLD, "mul2_hold3");
    idle(NRM, "mul2_done");

    // Long memory stall and a burst of branches
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NRM, "rst_perf");
    for (int i = 0; i < 20; i++)
      step(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, HLD, "busy_long");
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, BRF, "br_burst");
      idle(NRM, "br_burst_gap");
    end
    idle(NRM, "final");

    repeat (2) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
